alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter LOCK_TMO, default 8: consecutive idle cycles of a locked owner before forced lock release; used only when ALU_ARB_TIMEOUT_EN is defined.
REQ-002 i_clk input 1: clock, rising edge.
REQ-003 i_rst_n input 1: reset, asynchronous, active-low.
REQ-004 i_reqN_valid / o_reqN_ready, N=0,1, input/output 1 each: request handshake; transfer when both are high on a rising edge.
REQ-005 i_reqN_a, i_reqN_b input 12 each: signed operands.
REQ-006 i_reqN_inst input 3: ALU opcode, where 011 is MAC.
REQ-007 i_reqN_last input 1: high marks the final MAC of a chain.
REQ-008 o_alu_valid output 1, o_alu_a and o_alu_b output 12 each, o_alu_inst output 3: drive the shared ALU.
REQ-009 i_alu_valid input 1, i_alu_data input 12, i_alu_overflow input 1: ALU result, registered one cycle after ALU inputs.
REQ-010 o_rsp_valid output 1, o_rsp_id output 1, o_rsp_data output 12, o_rsp_overflow output 1: response and requester id; no backpressure.
REQ-011 o_lock_break output 1: one-cycle pulse on forced lock release.

Function
REQ-012 o_reqN_ready is combinational and is high only for the currently granted requester, and only while i_reqN_valid is high.
REQ-013 When unlocked and both requesters are valid, grant goes to the requester not served by the last unlocked accept; this rotation pointer is 0 after reset.
REQ-014 When unlocked and only one requester is valid, that requester is granted regardless of the pointer.
REQ-015 An accept at edge T registers the operands to o_alu_* at T+1 with o_alu_valid=1.
REQ-016 The result for an accept at edge T appears on o_rsp_* at T+3; o_rsp_id comes from a 2-deep id pipeline aligned with i_alu_valid.
REQ-017 o_rsp_data and o_rsp_overflow pass i_alu_data and i_alu_overflow through unchanged.
REQ-018 One request is accepted per cycle, giving full throughput and no bubbles between independent requests.
REQ-019 Two-state lock FSM, UNLOCKED and LOCKED(owner).
REQ-020 UNLOCKED -> LOCKED on accept of inst=011 with last=0.
REQ-021 LOCKED -> UNLOCKED on the owner's accept with last=1 or inst!=011.
REQ-022 While LOCKED, only the owner may be granted; the other requester's ready stays 0.
REQ-023 While LOCKED and the owner is not valid, the next cycle drives o_alu_inst=011, a=b=0, o_alu_valid=0, so the ALU accumulator is held (MAC of 0*0).
REQ-024 While UNLOCKED and there is no accept, the next cycle drives o_alu_inst=000, a=b=0, o_alu_valid=0.
REQ-025 On release from LOCKED, the pointer is set to favour the non-owner.
REQ-026 A MAC with last=1 accepted while UNLOCKED does not lock.
REQ-027 A lock release and an accept by the other requester never occur in the same cycle.

Reset
REQ-028 Asynchronous reset clears all outputs to 0, the lock FSM to UNLOCKED, the pointer to 0, the id pipeline valids and the timeout counter.
REQ-029 Transactions in flight at reset are discarded; no o_rsp_valid is produced for them.

Configuration
REQ-030 Macro ALU_ARB_TIMEOUT_EN defined: a counter increments on each LOCKED cycle with the owner not valid and clears on an owner accept.
REQ-031 With ALU_ARB_TIMEOUT_EN, when the counter reaches LOCK_TMO: FSM -> UNLOCKED, o_lock_break pulses 1 cycle, and the next ALU cycle drives inst=000 (accumulator cleared).
REQ-032 Without ALU_ARB_TIMEOUT_EN, the lock persists indefinitely and o_lock_break is tied to 0.

Verification
REQ-033 req0 ADD a=5, b=3 accepted at T -> o_rsp_valid=1, id=0, data=8, overflow=0 at T+3.
REQ-034 Both valid with ADD 1+1 continuously from reset -> grants alternate 0,1,0,1; responses arrive in grant order with data=2.
REQ-035 req0 MAC (2,3,last=0), (4,5,last=1) with req1 valid throughout -> req1 ready=0 until the second accept; responses 6 then 26; req1 granted next cycle.
REQ-036 req0 MAC (2,3,last=0), 3 idle cycles, then MAC (1,1,last=1) -> final response data=7 and o_alu_valid=0 on the bubble cycles.
REQ-037 ADD 2047+1 -> data=0x800, overflow=1.
REQ-038 ALU_ARB_TIMEOUT_EN with LOCK_TMO=8: locked owner idle 8 cycles -> o_lock_break single pulse, then a pending req1 is granted.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Bus bundle between two requesters, the shared ALU and the response sink.
// The arbiter takes the slave view; whoever drives requests and models the ALU takes master.
interface alu_arbiter_if;
    logic        i_req0_valid;
    logic        o_req0_ready;
    logic [11:0] i_req0_a;
    logic [11:0] i_req0_b;
    logic [2:0]  i_req0_inst;
    logic        i_req0_last;

    logic        i_req1_valid;
    logic        o_req1_ready;
    logic [11:0] i_req1_a;
    logic [11:0] i_req1_b;
    logic [2:0]  i_req1_inst;
    logic        i_req1_last;

    logic        o_alu_valid;
    logic [11:0] o_alu_a;
    logic [11:0] o_alu_b;
    logic [2:0]  o_alu_inst;
    logic        i_alu_valid;
    logic [11:0] i_alu_data;
    logic        i_alu_overflow;

    logic        o_rsp_valid;
    logic        o_rsp_id;
    logic [11:0] o_rsp_data;
    logic        o_rsp_overflow;
    logic        o_lock_break;

    modport slave (
        input  i_req0_valid, i_req0_a, i_req0_b, i_req0_inst, i_req0_last,
        input  i_req1_valid, i_req1_a, i_req1_b, i_req1_inst, i_req1_last,
        output o_req0_ready, o_req1_ready,
        output o_alu_valid, o_alu_a, o_alu_b, o_alu_inst,
        input  i_alu_valid, i_alu_data, i_alu_overflow,
        output o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_overflow, o_lock_break
    );

    modport master (
        output i_req0_valid, i_req0_a, i_req0_b, i_req0_inst, i_req0_last,
        output i_req1_valid, i_req1_a, i_req1_b, i_req1_inst, i_req1_last,
        input  o_req0_ready, o_req1_ready,
        input  o_alu_valid, o_alu_a, o_alu_b, o_alu_inst,
        output i_alu_valid, i_alu_data, i_alu_overflow,
        input  o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_overflow, o_lock_break
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter for a shared MAC-capable ALU, with MAC-chain locking.
// Define ALU_ARB_TIMEOUT_EN to force a lock release after LOCK_TMO idle owner cycles.
module alu_arbiter #(
    parameter int LOCK_TMO = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    alu_arbiter_if.slave bus
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_MAC = 3'b011;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    if (LOCK_TMO < 1) begin : g_bad_tmo
        $error("LOCK_TMO must be at least 1");
    end

    lock_state_e state_q;
    logic        owner_q;
    logic        ptr_q;
    logic        alu_valid_q;
    logic [11:0] alu_a_q;
    logic [11:0] alu_b_q;
    logic [2:0]  alu_inst_q;
    logic        id0_q;
    logic        id1_q;
    logic        id1_vld_q;
    logic        rsp_valid_q;
    logic        rsp_id_q;
    logic [11:0] rsp_data_q;
    logic        rsp_ovf_q;

    logic [1:0]  vld;
    logic        gnt_id;
    logic        accept;
    logic [11:0] sel_a;
    logic [11:0] sel_b;
    logic [2:0]  sel_inst;
    logic        sel_last;
    logic        sel_mac;
    logic        release_lock;
    logic        tmo_fire;

    assign vld = {bus.i_req1_valid, bus.i_req0_valid};

    // A locked owner is the only candidate; otherwise the pointer only breaks ties.
    always_comb begin
        gnt_id = 1'b0;
        accept = 1'b0;
        if (state_q == LOCKED) begin
            gnt_id = owner_q;
            accept = vld[owner_q];
        end else if (&vld) begin
            gnt_id = ptr_q;
            accept = 1'b1;
        end else begin
            gnt_id = vld[1];
            accept = |vld;
        end
    end

    assign bus.o_req0_ready = accept & ~gnt_id;
    assign bus.o_req1_ready = accept &  gnt_id;

    assign sel_a    = gnt_id ? bus.i_req1_a    : bus.i_req0_a;
    assign sel_b    = gnt_id ? bus.i_req1_b    : bus.i_req0_b;
    assign sel_inst = gnt_id ? bus.i_req1_inst : bus.i_req0_inst;
    assign sel_last = gnt_id ? bus.i_req1_last : bus.i_req0_last;
    assign sel_mac  = (sel_inst == OP_MAC);

    assign release_lock = (state_q == LOCKED) &&
                          ((accept && (!sel_mac || sel_last)) || tmo_fire);

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int CW = $clog2(LOCK_TMO + 1);

    logic [CW-1:0] tmo_cnt_q;
    logic          lock_break_q;

    // Fires on the LOCK_TMO-th consecutive idle owner cycle.
    assign tmo_fire = (state_q == LOCKED) && !vld[owner_q] &&
                      (tmo_cnt_q == CW'(LOCK_TMO - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_cnt_q    <= '0;
            lock_break_q <= 1'b0;
        end else begin
            lock_break_q <= tmo_fire;
            if (state_q != LOCKED || vld[owner_q] || tmo_fire) begin
                tmo_cnt_q <= '0;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + CW'(1);
            end
        end
    end

    assign bus.o_lock_break = lock_break_q;
`else
    assign tmo_fire         = 1'b0;
    assign bus.o_lock_break = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= UNLOCKED;
            owner_q     <= 1'b0;
            ptr_q       <= 1'b0;
            alu_valid_q <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_inst_q  <= OP_ADD;
            id0_q       <= 1'b0;
            id1_q       <= 1'b0;
            id1_vld_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_ovf_q   <= 1'b0;
        end else begin
            if (state_q == UNLOCKED) begin
                if (accept) begin
                    ptr_q <= ~gnt_id;
                    if (sel_mac && !sel_last) begin
                        state_q <= LOCKED;
                        owner_q <= gnt_id;
                    end
                end
            end else if (release_lock) begin
                state_q <= UNLOCKED;
                ptr_q   <= ~owner_q;
            end

            // Idle slots issue MAC 0*0 to hold the accumulator while locked, ADD 0+0 to clear it otherwise.
            alu_valid_q <= accept;
            if (accept) begin
                alu_a_q    <= sel_a;
                alu_b_q    <= sel_b;
                alu_inst_q <= sel_inst;
            end else begin
                alu_a_q    <= '0;
                alu_b_q    <= '0;
                alu_inst_q <= (state_q == LOCKED && !tmo_fire) ? OP_MAC : OP_ADD;
            end

            id0_q       <= gnt_id;
            id1_q       <= id0_q;
            id1_vld_q   <= alu_valid_q;
            rsp_valid_q <= bus.i_alu_valid & id1_vld_q;
            rsp_id_q    <= id1_q;
            rsp_data_q  <= bus.i_alu_data;
            rsp_ovf_q   <= bus.i_alu_overflow;
        end
    end

    assign bus.o_alu_valid    = alu_valid_q;
    assign bus.o_alu_a        = alu_a_q;
    assign bus.o_alu_b        = alu_b_q;
    assign bus.o_alu_inst     = alu_inst_q;
    assign bus.o_rsp_valid    = rsp_valid_q;
    assign bus.o_rsp_id       = rsp_id_q;
    assign bus.o_rsp_data     = rsp_data_q;
    assign bus.o_rsp_overflow = rsp_ovf_q;

endmodule
